// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO router: FSM encoding and the default memory map.
package mmio_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STROBE  = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    STROBE  = ST_STROBE,
    WAIT    = ST_WAIT,
    DONE    = ST_DONE,
    RELEASE = ST_RELEASE
  } state_t;

  // Default map, channel 0 in the low bits: UART, I/O regs, VGA, SDRAM.
  localparam logic [15:0] UART_BASE   = 16'h0000;
  localparam logic [15:0] UART_LIMIT  = 16'h0000;
  localparam logic [15:0] IO_BASE     = 16'h0001;
  localparam logic [15:0] IO_LIMIT    = 16'h0002;
  localparam logic [15:0] VGA_BASE    = 16'h1000;
  localparam logic [15:0] VGA_LIMIT   = 16'h4bff;
  localparam logic [15:0] SDRAM_BASE  = 16'h4c00;
  localparam logic [15:0] SDRAM_LIMIT = 16'hffff;

  localparam logic [63:0] DEF_BASES  = {SDRAM_BASE, VGA_BASE, IO_BASE, UART_BASE};
  localparam logic [63:0] DEF_LIMITS = {SDRAM_LIMIT, VGA_LIMIT, IO_LIMIT, UART_LIMIT};

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_router_if.sv
// CPU data port and slave-channel bundle. The router uses the slave modport;
// the CPU together with the channel devices sits on the master modport.
interface mmio_router_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int N_SLV  = 4
);
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic                    m_read;
  logic                    m_write;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_busy;
  logic                    m_ready;
  logic [N_SLV*ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV-1:0]        s_read;
  logic [N_SLV-1:0]        s_write;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;

  modport master (
    output m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
    input  m_rdata, m_busy, m_ready, s_addr, s_wdata, s_read, s_write
  );

  modport slave (
    input  m_addr, m_wdata, m_read, m_write, s_rdata, s_ready,
    output m_rdata, m_busy, m_ready, s_addr, s_wdata, s_read, s_write
  );
endinterface

// File: rtl/mmio_decode.sv
// Combinational address decode: window hits, lowest-index priority, rebasing.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int                      ADDR_W = 16,
  parameter int                      N_SLV  = 4,
  parameter logic [N_SLV*ADDR_W-1:0] BASES  = DEF_BASES,
  parameter logic [N_SLV*ADDR_W-1:0] LIMITS = DEF_LIMITS,
  parameter int                      CH_W   = ch_width(N_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [CH_W-1:0]   ch,
  output logic [ADDR_W-1:0] offset
);

  logic [N_SLV-1:0]  hit_vec;
  logic [ADDR_W-1:0] off_arr [N_SLV];

  // Window test done on the rebased offset: addr in [base, limit] iff
  // (addr - base) mod 2^W <= limit - base, given base <= limit.
  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_win
    localparam logic [ADDR_W-1:0] BASE_K  = BASES[gi*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] LIMIT_K = LIMITS[gi*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] SPAN_K  = LIMIT_K - BASE_K;
    localparam bit                VALID_K = (BASE_K <= LIMIT_K);

    assign off_arr[gi] = addr - BASE_K;
    assign hit_vec[gi] = VALID_K && (off_arr[gi] <= SPAN_K);
  end

  always_comb begin
    hit    = 1'b0;
    ch     = '0;
    offset = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit    = 1'b1;
        ch     = CH_W'(i);
        offset = off_arr[i];
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// MMIO router: table-driven decode, strobe/ready handshake to N channels,
// watchdog timeout and a sticky first-error capture register.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                      ADDR_W    = 16,
  parameter int                      DATA_W    = 16,
  parameter int                      N_SLV     = 4,
  parameter logic [N_SLV*ADDR_W-1:0] BASES     = DEF_BASES,
  parameter logic [N_SLV*ADDR_W-1:0] LIMITS    = DEF_LIMITS,
  parameter int                      TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]       ERR_RDATA = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  mmio_router_if.slave      bus,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr
);

  localparam int CH_W = ch_width(N_SLV);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] offset_reg, offset_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [15:0]       wd_reg, wd_next;
  logic              err_flag_reg, err_flag_next;
  logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

  logic              err_event;
  logic [ADDR_W-1:0] err_src;
  logic              dec_hit;
  logic [CH_W-1:0]   dec_ch;
  logic [ADDR_W-1:0] dec_offset;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  mmio_decode #(
    .ADDR_W (ADDR_W),
    .N_SLV  (N_SLV),
    .BASES  (BASES),
    .LIMITS (LIMITS),
    .CH_W   (CH_W)
  ) u_decode (
    .addr   (bus.m_addr),
    .hit    (dec_hit),
    .ch     (dec_ch),
    .offset (dec_offset)
  );

  // Only the latched channel's ready/rdata are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (ch_reg == CH_W'(i)) begin
        sel_ready = bus.s_ready[i];
        sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ch_next     = ch_reg;
    write_next  = write_reg;
    offset_next = offset_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    wd_next     = wd_reg;
    err_event   = 1'b0;
    err_src     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.m_read || bus.m_write) begin
          ch_next     = dec_ch;
          write_next  = bus.m_write;
          offset_next = dec_offset;
          addr_next   = bus.m_addr;
          wdata_next  = bus.m_wdata;
          if (dec_hit) begin
            state_next = STROBE;
          end else begin
            state_next = DONE;
            rdata_next = '0;
            err_event  = 1'b1;
            err_src    = bus.m_addr;
          end
        end
      end
      STROBE: begin
        wd_next = '0;
        if (sel_ready) begin
          state_next = DONE;
          rdata_next = write_reg ? '0 : sel_rdata;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          state_next = DONE;
          rdata_next = write_reg ? '0 : sel_rdata;
        end else if (wd_reg == 16'(TIMEOUT - 1)) begin
          state_next = DONE;
          rdata_next = ERR_RDATA;
          err_event  = 1'b1;
        end else begin
          wd_next = wd_reg + 16'd1;
        end
      end
      DONE: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        // A held level request must drop before another one is accepted.
        if (!bus.m_read && !bus.m_write) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A new error beats a simultaneous clear.
  always_comb begin
    err_flag_next = err_flag_reg;
    err_addr_next = err_addr_reg;
    if (err_event && (!err_flag_reg || err_clr)) begin
      err_flag_next = 1'b1;
      err_addr_next = err_src;
    end else if (err_clr) begin
      err_flag_next = 1'b0;
      err_addr_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_reg       <= '0;
      write_reg    <= 1'b0;
      offset_reg   <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      wd_reg       <= '0;
      err_flag_reg <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      ch_reg       <= ch_next;
      write_reg    <= write_next;
      offset_reg   <= offset_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      wd_reg       <= wd_next;
      err_flag_reg <= err_flag_next;
      err_addr_reg <= err_addr_next;
    end
  end

  assign bus.m_busy  = (state_reg == STROBE) || (state_reg == WAIT);
  assign bus.m_ready = (state_reg == DONE);
  assign bus.m_rdata = rdata_reg;
  assign bus.s_wdata = wdata_reg;
  assign err_flag    = err_flag_reg;
  assign err_addr    = err_addr_reg;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_lane
    assign bus.s_addr[gi*ADDR_W +: ADDR_W] = offset_reg;
    assign bus.s_read[gi]  = (state_reg == STROBE) && !write_reg && (ch_reg == CH_W'(gi));
    assign bus.s_write[gi] = (state_reg == STROBE) &&  write_reg && (ch_reg == CH_W'(gi));
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench: default map instance (a) and an overlapping-map, short-timeout instance (b).
module tb_mmio_router;
  import mmio_pkg::*;

  typedef struct {
    logic [31:0] strb;
    logic [31:0] off;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic [31:0] off_done;
    logic [31:0] wdat_done;
    int          lat;
    int          nstrb;
    int          nrdy;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic        m_read = 1'b0;
  logic        m_write = 1'b0;
  logic [63:0] s_rdata = {16'hbeef, 16'hc0de, 16'h2222, 16'h1111};
  logic [3:0]  s_ready = '0;
  logic        err_clr = 1'b0;
  logic        err_flag_a, err_flag_b;
  logic [15:0] err_addr_a, err_addr_b;

  int n_run = 0;
  int n_fail = 0;
  int strb_cnt_a = 0, rdy_cnt_a = 0, strb_cnt_b = 0, rdy_cnt_b = 0;

  always #5 clk = ~clk;

  mmio_router_if #(.ADDR_W(16), .DATA_W(16), .N_SLV(4)) bus_a ();
  mmio_router_if #(.ADDR_W(16), .DATA_W(16), .N_SLV(4)) bus_b ();

  assign bus_a.m_addr  = m_addr;
  assign bus_a.m_wdata = m_wdata;
  assign bus_a.m_read  = m_read;
  assign bus_a.m_write = m_write;
  assign bus_a.s_rdata = s_rdata;
  assign bus_a.s_ready = s_ready;
  assign bus_b.m_addr  = m_addr;
  assign bus_b.m_wdata = m_wdata;
  assign bus_b.m_read  = m_read;
  assign bus_b.m_write = m_write;
  assign bus_b.s_rdata = s_rdata;
  assign bus_b.s_ready = s_ready;

  mmio_router #(
    .ADDR_W(16), .DATA_W(16), .N_SLV(4)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .err_flag(err_flag_a), .err_addr(err_addr_a), .err_clr(err_clr)
  );

  mmio_router #(
    .ADDR_W(16), .DATA_W(16), .N_SLV(4),
    .BASES ({16'h4c00, 16'h1000, 16'h0500, 16'h0400}),
    .LIMITS({16'hffff, 16'h4bff, 16'h06ff, 16'h05ff}),
    .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .err_flag(err_flag_b), .err_addr(err_addr_b), .err_clr(err_clr)
  );

  always @(negedge clk) begin
    strb_cnt_a <= strb_cnt_a + $countones({bus_a.s_read, bus_a.s_write});
    rdy_cnt_a  <= rdy_cnt_a + int'(bus_a.m_ready);
    strb_cnt_b <= strb_cnt_b + $countones({bus_b.s_read, bus_b.s_write});
    rdy_cnt_b  <= rdy_cnt_b + int'(bus_b.m_ready);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // delay = cycles after the strobe cycle at which all s_ready lanes pulse; <0 means never.
  task automatic xfer(input bit on_b, input logic [15:0] addr, input logic wr,
                      input logic [15:0] wdata, input int delay, output res_t r);
    int c;
    int s0;
    int q0;
    s0 = on_b ? strb_cnt_b : strb_cnt_a;
    q0 = on_b ? rdy_cnt_b : rdy_cnt_a;
    m_addr  = addr;
    m_wdata = wdata;
    m_write = wr;
    m_read  = ~wr;
    tick();
    r.lat  = 1;
    r.strb = 32'(on_b ? (wr ? bus_b.s_write : bus_b.s_read) : (wr ? bus_a.s_write : bus_a.s_read));
    r.off  = 32'(on_b ? bus_b.s_addr[15:0] : bus_a.s_addr[15:0]);
    r.wdat = 32'(on_b ? bus_b.s_wdata : bus_a.s_wdata);
    c = 0;
    while (!(on_b ? bus_b.m_ready : bus_a.m_ready) && r.lat < 300) begin
      s_ready = (c == delay) ? 4'hf : 4'h0;
      tick();
      c++;
      r.lat++;
    end
    s_ready     = 4'h0;
    r.rdata     = 32'(on_b ? bus_b.m_rdata : bus_a.m_rdata);
    r.off_done  = 32'(on_b ? bus_b.s_addr[63:48] : bus_a.s_addr[63:48]);
    r.wdat_done = 32'(on_b ? bus_b.s_wdata : bus_a.s_wdata);
    m_read  = 1'b0;
    m_write = 1'b0;
    tick();
    tick();
    r.nstrb = (on_b ? strb_cnt_b : strb_cnt_a) - s0;
    r.nrdy  = (on_b ? rdy_cnt_b : rdy_cnt_a) - q0;
    $display("[TB] %s %s addr=%h lat=%0d rdata=%h strb=%h", on_b ? "b" : "a",
             wr ? "wr" : "rd", addr, r.lat, r.rdata[15:0], r.strb[3:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [15:0] t_addr [6] = '{16'h0000, 16'h0002, 16'h1000, 16'h4bff, 16'hffff, 16'h0fff};
  logic [31:0] t_strb [6] = '{32'h1, 32'h2, 32'h4, 32'h4, 32'h8, 32'h0};
  logic [31:0] t_off  [6] = '{32'h0, 32'h1, 32'h0, 32'h3bff, 32'hb3ff, 32'h0};
  logic [31:0] t_rd   [6] = '{32'h1111, 32'h2222, 32'hc0de, 32'hc0de, 32'hbeef, 32'h0};
  int          t_lat  [6] = '{3, 3, 3, 3, 3, 1};

  initial begin
    res_t r;
    int   s0;
    int   q0;

    tick();
    tick();
    check("rst_ready",  32'(bus_a.m_ready), 32'h0);
    check("rst_busy",   32'(bus_a.m_busy), 32'h0);
    check("rst_rdata",  32'(bus_a.m_rdata), 32'h0);
    check("rst_strobe", 32'({bus_a.s_read, bus_a.s_write}), 32'h0);
    check("rst_saddr",  bus_a.s_addr[31:0], 32'h0);
    check("rst_swdata", 32'(bus_a.s_wdata), 32'h0);
    check("rst_errf",   32'(err_flag_a), 32'h0);
    check("rst_erra",   32'(err_addr_a), 32'h0);
    rst = 1'b0;
    tick();

    // Read ch3 with a 4-cycle slave.
    xfer(1'b0, 16'h4c10, 1'b0, 16'h0000, 4, r);
    check("t1_strb",  r.strb, 32'h8);
    check("t1_off",   r.off_done, 32'h0010);
    check("t1_rdata", r.rdata, 32'hbeef);
    check("t1_lat",   32'(r.lat), 32'd6);
    check("t1_nstrb", 32'(r.nstrb), 32'd1);
    check("t1_nrdy",  32'(r.nrdy), 32'd1);
    check("t1_errf",  32'(err_flag_a), 32'h0);
    check("t1_hold",  32'(bus_a.m_rdata), 32'hbeef);

    // Write ch2 with ready in the strobe cycle.
    xfer(1'b0, 16'h1234, 1'b1, 16'h00a5, 0, r);
    check("t2_strb",  r.strb, 32'h4);
    check("t2_off",   r.off, 32'h0234);
    check("t2_wdat",  r.wdat, 32'h00a5);
    check("t2_offd",  r.off_done, 32'h0234);
    check("t2_wdatd", r.wdat_done, 32'h00a5);
    check("t2_rdata", r.rdata, 32'h0);
    check("t2_lat",   32'(r.lat), 32'd2);
    check("t2_nstrb", 32'(r.nstrb), 32'd1);

    // Window boundaries and an unmapped hole.
    for (int i = 0; i < 6; i++) begin
      xfer(1'b0, t_addr[i], 1'b0, 16'h0000, 1, r);
      check($sformatf("dec%0d_strb", i), r.strb, t_strb[i]);
      check($sformatf("dec%0d_off", i), r.off_done, t_off[i]);
      check($sformatf("dec%0d_rdata", i), r.rdata, t_rd[i]);
      check($sformatf("dec%0d_lat", i), 32'(r.lat), 32'(t_lat[i]));
    end
    check("unm_errf", 32'(err_flag_a), 32'h1);
    check("unm_erra", 32'(err_addr_a), 32'h0fff);

    xfer(1'b0, 16'h0003, 1'b0, 16'h0000, 1, r);
    check("unm2_erra", 32'(err_addr_a), 32'h0fff);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_errf", 32'(err_flag_a), 32'h0);
    check("clr_erra", 32'(err_addr_a), 32'h0);

    xfer(1'b0, 16'h0004, 1'b0, 16'h0000, 1, r);
    check("unm3_erra", 32'(err_addr_a), 32'h0004);
    m_addr  = 16'h0800;
    m_read  = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clrwin_errf", 32'(err_flag_a), 32'h1);
    check("clrwin_erra", 32'(err_addr_a), 32'h0800);
    m_read = 1'b0;
    tick();
    tick();

    // Overlapping windows and watchdog on instance b.
    do_reset();
    xfer(1'b1, 16'h0500, 1'b0, 16'h0000, 0, r);
    check("ovl_strb",  r.strb, 32'h1);
    check("ovl_off",   r.off_done, 32'h0100);
    check("ovl_rdata", r.rdata, 32'h1111);
    xfer(1'b1, 16'h0600, 1'b0, 16'h0000, 0, r);
    check("ovl1_strb", r.strb, 32'h2);
    check("ovl1_off",  r.off_done, 32'h0100);

    xfer(1'b1, 16'h2000, 1'b0, 16'h0000, -1, r);
    check("to_strb",  r.strb, 32'h4);
    check("to_rdata", r.rdata, 32'hffff);
    check("to_lat",   32'(r.lat), 32'd10);
    check("to_errf",  32'(err_flag_b), 32'h1);
    check("to_erra",  32'(err_addr_b), 32'h2000);
    xfer(1'b1, 16'h3000, 1'b1, 16'h0000, -1, r);
    check("to2_rdata", r.rdata, 32'hffff);
    check("to2_lat",   32'(r.lat), 32'd10);
    check("to2_erra",  32'(err_addr_b), 32'h2000);

    // Held level request.
    do_reset();
    xfer(1'b0, 16'h0800, 1'b0, 16'h0000, 1, r);
    check("pre_errf", 32'(err_flag_a), 32'h1);
    s0 = strb_cnt_a;
    q0 = rdy_cnt_a;
    s_ready = 4'hf;
    m_addr  = 16'h0001;
    m_read  = 1'b1;
    repeat (20) tick();
    check("held_state", 32'(dut_a.state_reg), 32'(RELEASE));
    check("held_busy",  32'(bus_a.m_busy), 32'h0);
    m_read  = 1'b0;
    s_ready = 4'h0;
    tick();
    tick();
    check("held_nstrb", 32'(strb_cnt_a - s0), 32'd1);
    check("held_nrdy",  32'(rdy_cnt_a - q0), 32'd1);
    check("held_rdata", 32'(bus_a.m_rdata), 32'h2222);
    check("held_idle",  32'(dut_a.state_reg), 32'(IDLE));
    $display("[TB] a held rd addr=0001 strobes=%0d readys=%0d", strb_cnt_a - s0, rdy_cnt_a - q0);

    // Reset while waiting on the slave.
    q0 = rdy_cnt_a;
    m_addr  = 16'h4c10;
    m_wdata = 16'h5a5a;
    m_read  = 1'b1;
    tick();
    tick();
    tick();
    check("wrst_busy", 32'(bus_a.m_busy), 32'h1);
    rst    = 1'b1;
    m_read = 1'b0;
    tick();
    check("wrst_ready",  32'(bus_a.m_ready), 32'h0);
    check("wrst_busyr",  32'(bus_a.m_busy), 32'h0);
    check("wrst_rdata",  32'(bus_a.m_rdata), 32'h0);
    check("wrst_strobe", 32'({bus_a.s_read, bus_a.s_write}), 32'h0);
    check("wrst_saddr",  bus_a.s_addr[63:32], 32'h0);
    check("wrst_swdata", 32'(bus_a.s_wdata), 32'h0);
    check("wrst_errf",   32'(err_flag_a), 32'h0);
    rst = 1'b0;
    tick();
    check("wrst_nrdy", 32'(rdy_cnt_a - q0), 32'd0);
    $display("[TB] a reset during WAIT addr=4c10");
    xfer(1'b0, 16'h4c10, 1'b0, 16'h0000, 2, r);
    check("post_strb",  r.strb, 32'h8);
    check("post_rdata", r.rdata, 32'hbeef);
    check("post_lat",   32'(r.lat), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
